// File: rtl/ct_rtu_pkg.sv
// Shared RTU types and constants for one-hot <-> binary entry conversion.
package ct_rtu_pkg;
  localparam int RTU_ENTRY    = 8;
  localparam int RTU_NUM_W    = 3;
  localparam int RTU_ERRCNT_W = 8;

  typedef struct packed {
    logic [RTU_NUM_W-1:0] num;
    logic                 err;
  } rtu_enc_t;
endpackage

// File: rtl/ct_rtu_compress_8.sv
// Combinational 8-bit one-hot to 3-bit index encoder with legality check.
module ct_rtu_compress_8
  import ct_rtu_pkg::*;
(
  input  logic [RTU_ENTRY-1:0] onehot_i,
  output rtu_enc_t             enc_o
);

  logic [3:0] pop;

  // Scanning from the top down lets the lowest set bit win on multi-hot input.
  always_comb begin
    enc_o = '0;
    pop   = '0;
    for (int i = RTU_ENTRY - 1; i >= 0; i--) begin
      if (onehot_i[i]) enc_o.num = RTU_NUM_W'(i);
      pop = pop + 4'(onehot_i[i]);
    end
    enc_o.err = (pop != 4'd1);
  end

endmodule

// File: rtl/ct_rtu_compress_8_buf.sv
// One-hot to binary index converter behind a 2-entry valid/ready buffer, with error tracking.
module ct_rtu_compress_8_buf
  import ct_rtu_pkg::*;
(
  input  logic                    cpuclk,
  input  logic                    cpurst_b,
  input  logic                    x_vld,
  input  logic [RTU_ENTRY-1:0]    x_onehot,
  output logic                    x_rdy,
  output logic                    y_vld,
  output logic [RTU_NUM_W-1:0]    y_num,
  output logic                    y_err,
  input  logic                    y_rdy,
  input  logic                    clr_err,
  output logic                    err_sticky,
  output logic [RTU_ERRCNT_W-1:0] err_cnt
);

  localparam int DEPTH = 2;
  localparam int CNT_W = RTU_ERRCNT_W;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  rtu_enc_t         enc;
  rtu_enc_t         mem_q [DEPTH];
  logic             wptr_q, rptr_q;
  logic [1:0]       occ_q, occ_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc, pop;

  ct_rtu_compress_8 u_enc (
    .onehot_i (x_onehot),
    .enc_o    (enc)
  );

  // Ready depends on registered occupancy only, so no path from y_rdy to x_rdy.
  assign x_rdy = (occ_q < 2'(DEPTH));
  assign y_vld = (occ_q != 2'd0);
  assign y_num = mem_q[rptr_q].num;
  assign y_err = mem_q[rptr_q].err;
  assign acc   = x_vld & x_rdy;
  assign pop   = y_vld & y_rdy;

  assign err_sticky = sticky_q;
  assign err_cnt    = cnt_q;

  always_comb begin
    occ_d = occ_q;
    case ({acc, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // A clear in the same cycle as an illegal accept restarts the count at one.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (clr_err) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end
    if (acc && enc.err) begin
      sticky_d = 1'b1;
      cnt_d    = sat_inc(cnt_d);
    end
  end

  always_ff @(posedge cpuclk) begin
    if (!cpurst_b) begin
      occ_q    <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (acc) begin
        mem_q[wptr_q] <= enc;
        wptr_q        <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      occ_q    <= occ_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ct_rtu_compress_8_buf.sv
// Directed plus randomized bench for ct_rtu_compress_8_buf against a queue-based reference model.
module tb_ct_rtu_compress_8_buf;

  logic       cpuclk = 1'b0;
  logic       cpurst_b;
  logic       x_vld;
  logic [7:0] x_onehot;
  logic       x_rdy;
  logic       y_vld;
  logic [2:0] y_num;
  logic       y_err;
  logic       y_rdy;
  logic       clr_err;
  logic       err_sticky;
  logic [7:0] err_cnt;

  int passed = 0;
  int total  = 0;

  // Reference model: FIFO of expected results plus error bookkeeping.
  int unsigned m_num [$];
  bit          m_err [$];
  int unsigned m_cnt;
  bit          m_sticky;
  bit          last_acc;

  always #5 cpuclk = ~cpuclk;

  ct_rtu_compress_8_buf dut (
    .cpuclk     (cpuclk),
    .cpurst_b   (cpurst_b),
    .x_vld      (x_vld),
    .x_onehot   (x_onehot),
    .x_rdy      (x_rdy),
    .y_vld      (y_vld),
    .y_num      (y_num),
    .y_err      (y_err),
    .y_rdy      (y_rdy),
    .clr_err    (clr_err),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Index of the lowest set bit via isolating it arithmetically; 0 for an empty vector.
  function automatic int unsigned ref_num(input logic [7:0] v);
    logic [7:0] lo;
    lo = v & (~v + 8'd1);
    return (lo == 8'd0) ? 0 : $clog2(lo);
  endfunction

  function automatic bit ref_err(input logic [7:0] v);
    return $countones(v) != 1;
  endfunction

  task automatic check_outputs();
    chk("x_rdy", x_rdy, m_num.size() < 2);
    chk("y_vld", y_vld, m_num.size() > 0);
    if (m_num.size() > 0) begin
      chk("y_num", y_num, m_num[0]);
      chk("y_err", y_err, m_err[0]);
    end
    chk("err_sticky", err_sticky, m_sticky);
    chk("err_cnt", err_cnt, m_cnt);
  endtask

  // Called at a falling edge: drive, clock once, update model, check at next falling edge.
  task automatic step(input bit vld, input logic [7:0] oh, input bit rdy, input bit clr);
    bit acc, pop;
    x_vld    = vld;
    x_onehot = vld ? oh : 8'($urandom);
    y_rdy    = rdy;
    clr_err  = clr;
    acc = vld && (m_num.size() < 2);
    pop = rdy && (m_num.size() > 0);
    @(posedge cpuclk);
    if (pop) begin
      void'(m_num.pop_front());
      void'(m_err.pop_front());
    end
    if (acc) begin
      m_num.push_back(ref_num(oh));
      m_err.push_back(ref_err(oh));
    end
    if (clr) begin
      m_cnt    = 0;
      m_sticky = 0;
    end
    if (acc && ref_err(oh)) begin
      m_sticky = 1;
      if (m_cnt < 255) m_cnt++;
    end
    last_acc = acc;
    @(negedge cpuclk);
    check_outputs();
  endtask

  task automatic do_reset();
    cpurst_b = 1'b0;
    x_vld    = 1'b1;
    x_onehot = 8'h00;
    y_rdy    = 1'b0;
    clr_err  = 1'b0;
    @(posedge cpuclk);
    m_num.delete();
    m_err.delete();
    m_cnt    = 0;
    m_sticky = 0;
    @(negedge cpuclk);
    cpurst_b = 1'b1;
    x_vld    = 1'b0;
    check_outputs();
    chk("rst_y_num", y_num, 0);
    chk("rst_y_err", y_err, 0);
  endtask

  initial begin
    cpurst_b = 1'b0;
    x_vld    = 1'b0;
    x_onehot = 8'h00;
    y_rdy    = 1'b0;
    clr_err  = 1'b0;
    @(negedge cpuclk);
    do_reset();

    // Single vector: visible the cycle after accept, gone the cycle after that.
    step(1, 8'h20, 1, 0);
    chk("single_num", y_num, 5);
    chk("single_vld", y_vld, 1);
    step(0, 8'h00, 1, 0);
    chk("single_drain", y_vld, 0);

    // Streaming at full rate.
    for (int k = 0; k < 8; k++) step(1, 8'(1 << k), 1, 0);
    step(0, 8'h00, 1, 0);
    chk("stream_cnt", err_cnt, 0);

    // Backpressure: fill, block third, then drain while re-offering it.
    step(1, 8'h04, 0, 0);
    step(1, 8'h08, 0, 0);
    step(1, 8'h10, 0, 0);
    chk("full_xrdy", x_rdy, 0);
    last_acc = 0;
    for (int k = 0; k < 6 && !last_acc; k++) step(1, 8'h10, 1, 0);
    chk("reoffer_acc", last_acc, 1);
    for (int k = 0; k < 3; k++) step(0, 8'h00, 1, 0);

    // Illegal vectors.
    step(1, 8'h00, 1, 0);
    chk("zero_num", y_num, 0);
    chk("zero_err", y_err, 1);
    step(1, 8'h18, 1, 0);
    chk("multi_num", y_num, 3);
    chk("multi_err", y_err, 1);
    step(0, 8'h00, 1, 0);
    chk("illegal_cnt", err_cnt, 2);
    chk("illegal_sticky", err_sticky, 1);

    // Saturation and clear interactions.
    for (int k = 0; k < 260; k++) step(1, (k % 2) ? 8'h00 : 8'hff, 1, 0);
    chk("sat_cnt", err_cnt, 255);
    step(1, 8'h01, 1, 1);
    chk("clr_cnt", err_cnt, 0);
    chk("clr_sticky", err_sticky, 0);
    step(1, 8'h03, 1, 1);
    chk("clr_acc_cnt", err_cnt, 1);
    chk("clr_acc_sticky", err_sticky, 1);
    step(0, 8'h00, 1, 0);

    // Reset with a full buffer discards everything.
    step(1, 8'h04, 0, 0);
    step(1, 8'h08, 0, 0);
    do_reset();
    step(0, 8'h00, 1, 0);
    chk("post_rst_vld", y_vld, 0);
    step(1, 8'h40, 1, 0);
    chk("post_rst_num", y_num, 6);
    step(0, 8'h00, 1, 0);

    // Randomized traffic.
    for (int k = 0; k < 500; k++) begin
      logic [7:0] oh;
      oh = ($urandom_range(0, 3) != 0) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      step($urandom_range(0, 3) != 0, oh, $urandom_range(0, 2) != 0,
           $urandom_range(0, 19) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
